// File: rtl/aoc_d16_pkg.sv
// Shared definitions for the puzzle-string RAM loader.
// Holds the ASCII constants, bus widths, packing constants and loader state enum.
package aoc_d16_pkg;

   localparam int unsigned ADDR_W           = 10;
   localparam int unsigned DATA_W           = 64;
   localparam int unsigned NIBBLES_PER_WORD = 16;
   localparam int unsigned NIB_IDX_W        = $clog2(NIBBLES_PER_WORD);
   localparam int unsigned SHIFT_W          = $clog2(DATA_W);
   localparam int unsigned COUNT_W          = 14;
   localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(4095);

   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_UC_A  = 8'h41;
   localparam logic [7:0] ASCII_LC_A  = 8'h61;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2,
      S_DONE    = 2'd3
   } load_state_e;

endpackage

// File: rtl/ram_loader_if.sv
// Character stream + RAM request bus of the loader.
//   in_data/in_valid/in_ready : ASCII character stream handshake
//   ramloader_*               : single-port RAM write request (active-low enables)
// master = loader side, slave = source/RAM controller side.
interface ram_loader_if;
   import aoc_d16_pkg::*;

   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              ramloader_stall;
   logic              ramloader_ceb;
   logic              ramloader_web;
   logic [ADDR_W-1:0] ramloader_addr;
   logic [DATA_W-1:0] ramloader_wdata;

   modport master (
      input  in_data, in_valid, ramloader_stall,
      output in_ready, ramloader_ceb, ramloader_web, ramloader_addr, ramloader_wdata
   );

   modport slave (
      output in_data, in_valid, ramloader_stall,
      input  in_ready, ramloader_ceb, ramloader_web, ramloader_addr, ramloader_wdata
   );

endinterface

// File: rtl/hex_ascii_decode.sv
// Combinational ASCII classifier: hex digit -> nibble, LF/CR -> terminator.
//   ascii   : input character
//   nibble  : digit value (0 when not a hex digit)
//   is_hex  : character is an accepted hex digit
//   is_term : character is LF or CR
// Define RAM_LOADER_LOWERCASE_EN to also accept a-f as digits 10-15.
module hex_ascii_decode
   import aoc_d16_pkg::*;
(
   input  logic [7:0] ascii,
   output logic [3:0] nibble,
   output logic       is_hex,
   output logic       is_term
);

   always_comb begin
      nibble  = 4'd0;
      is_hex  = 1'b0;
      is_term = 1'b0;
      if (ascii >= ASCII_0 && ascii <= ASCII_0 + 8'd9) begin
         is_hex = 1'b1;
         nibble = 4'(ascii - ASCII_0);
      end
      else if (ascii >= ASCII_UC_A && ascii <= ASCII_UC_A + 8'd5) begin
         is_hex = 1'b1;
         nibble = 4'(ascii - ASCII_UC_A + 8'd10);
      end
`ifdef RAM_LOADER_LOWERCASE_EN
      else if (ascii >= ASCII_LC_A && ascii <= ASCII_LC_A + 8'd5) begin
         is_hex = 1'b1;
         nibble = 4'(ascii - ASCII_LC_A + 8'd10);
      end
`endif
      else if (ascii == ASCII_LF || ascii == ASCII_CR) begin
         is_term = 1'b1;
      end
   end

endmodule

// File: rtl/ram_loader.sv
// Packs an ASCII hex string into 64-bit words (MSB nibble first) and writes
// them to consecutive RAM addresses starting at 0.
//   clk, reset   : clock, synchronous active-high reset
//   bus          : ram_loader_if.master (char stream in, RAM request out)
//   load_done    : string fully stored, held until reset
//   nibble_count : hex digits stored, saturating at 4095
//   load_error   : sticky; invalid character or write past the last address
// Optional: RAM_LOADER_LOWERCASE_EN enables lowercase hex digits.
module ram_loader
   import aoc_d16_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   ram_loader_if.master        bus,
   output logic                load_done,
   output logic [COUNT_W-1:0]  nibble_count,
   output logic                load_error
);

   load_state_e          state, state_next;
   logic [DATA_W-1:0]    word_q, word_next;
   logic [NIB_IDX_W-1:0] idx_q, idx_next;
   logic [ADDR_W-1:0]    addr_q, addr_next;
   logic                 full_q, full_next;
   logic                 term_q, term_next;
   logic [COUNT_W-1:0]   count_q, count_next;
   logic                 err_q, err_next;
   logic                 in_ready_q, req_n_q, done_q;

   logic [3:0]           dec_nibble;
   logic                 dec_is_hex, dec_is_term;
   logic                 accept;
   logic [SHIFT_W-1:0]   shift;

   hex_ascii_decode u_dec (
      .ascii   (bus.in_data),
      .nibble  (dec_nibble),
      .is_hex  (dec_is_hex),
      .is_term (dec_is_term)
   );

   assign accept = in_ready_q & bus.in_valid;
   // Nibble idx lands at bit 4*(15-idx) so the first digit is the MSB nibble.
   assign shift  = SHIFT_W'((NIBBLES_PER_WORD - 1 - 32'(idx_q)) * 4);

   // Next-state and datapath update.
   always_comb begin
      state_next = state;
      word_next  = word_q;
      idx_next   = idx_q;
      addr_next  = addr_q;
      full_next  = full_q;
      term_next  = term_q;
      count_next = count_q;
      err_next   = err_q;
      case (state)
         S_IDLE, S_COLLECT: begin
            if (accept) begin
               if (dec_is_hex) begin
                  word_next = word_q | (DATA_W'(dec_nibble) << shift);
                  idx_next  = idx_q + NIB_IDX_W'(1);
                  if (count_q != COUNT_MAX) count_next = count_q + COUNT_W'(1);
                  if (idx_q == NIB_IDX_W'(NIBBLES_PER_WORD - 1)) begin
                     state_next = S_WRITE;
                     term_next  = 1'b0;
                  end
                  else begin
                     state_next = S_COLLECT;
                  end
               end
               else if (dec_is_term) begin
                  // Unused low nibbles are already zero in the cleared buffer.
                  if (idx_q == '0) begin
                     state_next = S_DONE;
                  end
                  else begin
                     state_next = S_WRITE;
                     term_next  = 1'b1;
                  end
               end
               else begin
                  err_next = 1'b1;
               end
            end
         end
         S_WRITE: begin
            // Past the last address the write is dropped without a RAM access.
            if (!bus.ramloader_stall || full_q) begin
               word_next  = '0;
               idx_next   = '0;
               state_next = term_q ? S_DONE : S_COLLECT;
               if (full_q)              err_next  = 1'b1;
               else if (addr_q == '1)   full_next = 1'b1;
               else                     addr_next = addr_q + ADDR_W'(1);
            end
         end
         S_DONE: begin
         end
         default: state_next = S_IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         word_q     <= '0;
         idx_q      <= '0;
         addr_q     <= '0;
         full_q     <= 1'b0;
         term_q     <= 1'b0;
         count_q    <= '0;
         err_q      <= 1'b0;
         in_ready_q <= 1'b0;
         req_n_q    <= 1'b1;
         done_q     <= 1'b0;
      end
      else begin
         state      <= state_next;
         word_q     <= word_next;
         idx_q      <= idx_next;
         addr_q     <= addr_next;
         full_q     <= full_next;
         term_q     <= term_next;
         count_q    <= count_next;
         err_q      <= err_next;
         in_ready_q <= (state_next == S_IDLE) || (state_next == S_COLLECT);
         req_n_q    <= !((state_next == S_WRITE) && !full_next);
         done_q     <= (state_next == S_DONE);
      end
   end

   assign bus.in_ready        = in_ready_q;
   assign bus.ramloader_ceb   = req_n_q;
   assign bus.ramloader_web   = req_n_q;
   assign bus.ramloader_addr  = addr_q;
   assign bus.ramloader_wdata = word_q;
   assign load_done           = done_q;
   assign nibble_count        = count_q;
   assign load_error          = err_q;

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 Ports, in order:
- clk, input, 1 -- sole clock; all state changes on its rising edge.
- reset, input, 1 -- synchronous, active-high.
- in_data, input, 8 -- ASCII character of the puzzle hex string.
- in_valid, input, 1 -- in_data is valid.
- in_ready, output, 1 -- loader accepts in_data this cycle.
- ramloader_stall, input, 1 -- controller has not granted the pending RAM access.
- ramloader_ceb, output, 1 -- RAM chip enable, active-low.
- ramloader_web, output, 1 -- RAM write enable, active-low.
- ramloader_addr, output, 10 -- RAM word address.
- ramloader_wdata, output, 64 -- RAM write data.
- load_done, output, 1 -- string fully stored.
- nibble_count, output, 14 -- total hex digits stored.
- load_error, output, 1 -- sticky error flag.

Function
REQ-003 SHALL transfer a character only on a cycle where in_valid and in_ready are both high.
REQ-004 SHALL accept 0-9 and A-F as hex digits, each giving one 4-bit nibble.
REQ-005 SHALL pack nibbles MSB-first: nibble 0 of a word goes to bits [63:60], nibble 15 to bits [3:0].
REQ-006 SHALL treat 0x0A (LF) and 0x0D (CR) as the string terminator.
REQ-007 SHALL treat any other character as invalid: consume it, store no nibble, set load_error.
REQ-008 SHALL use four states:
- IDLE: in_ready=1; the first accepted hex digit moves to COLLECT.
- COLLECT: in_ready=1; after the 16th nibble, or on a terminator, moves to WRITE.
- WRITE: in_ready=0; RAM request held.
- DONE: in_ready=0; load_done=1.
REQ-009 In WRITE, SHALL drive ramloader_ceb=0 and ramloader_web=0, and hold addr and wdata stable until a cycle with ramloader_stall=0.
REQ-010 On the cycle with ramloader_stall=0 in WRITE, the write is accepted. The next cycle SHALL:
- deassert ceb/web to 1;
- increment the address by 1;
- clear the word buffer;
- go to COLLECT, or to DONE if a terminator caused the write.
REQ-011 A terminator with a partial word SHALL zero-fill the unused low nibbles, then write.
REQ-012 A terminator with zero pending nibbles SHALL go straight to DONE without a write.
REQ-013 A terminator in IDLE (empty string) SHALL go to DONE with nibble_count=0.
REQ-014 nibble_count SHALL increment once per stored nibble, saturating at 4095.
REQ-015 A write required when the address has already passed 1023 (buffer full) SHALL be dropped: no RAM access, load_error set, transition as if the write was accepted. The address SHALL NOT wrap.
REQ-016 DONE SHALL be held until reset.
REQ-017 ramloader_wdata and ramloader_addr SHALL be registered outputs. No combinational path from in_* to ramloader_*.
REQ-018 The last RAM write of a terminated string SHALL complete no earlier than 2 cycles after the terminator is accepted.

Reset
REQ-019 While reset=1, outputs SHALL be:
- in_ready=0
- ramloader_ceb=1, ramloader_web=1
- ramloader_addr=0, ramloader_wdata=0
- load_done=0, nibble_count=0, load_error=0
- state=IDLE
REQ-020 Reset asserted mid-WRITE SHALL abandon the write: ceb=1 on the next edge, and the partial word is discarded.
REQ-021 in_ready SHALL go to 1 on the first cycle after reset deasserts.

Configuration
REQ-022 With macro RAM_LOADER_LOWERCASE_EN defined, a-f SHALL also be accepted as hex 10-15.
REQ-023 Without the macro, a-f SHALL be treated as invalid characters (REQ-007).

Structure
REQ-024 Package aoc_d16_pkg SHALL hold:
- the ASCII constants (LF, CR, '0', 'A', 'a');
- the loader state enum;
- the RAM address width (10) and data width (64);
- the nibbles-per-word constant (16).
REQ-025 SHALL instantiate one combinational sub-module, hex_ascii_decode: in 8-bit char, out 4-bit nibble plus is_hex and is_term flags.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- "D2FE28" then LF, no stall -> one write, addr 0, wdata 0xD2FE280000000000; nibble_count=6; load_done=1; load_error=0.
- 17 x "F" then LF -> write addr 0 = 0xFFFFFFFFFFFFFFFF, write addr 1 = 0xF000000000000000; nibble_count=17.
- ramloader_stall held 1 for 5 cycles during the first write -> ceb=0 and addr/wdata stable for 6 cycles; exactly one write; in_ready=0 throughout.
- "8A" then "G" then "3" then LF -> wdata 0x8A30000000000000; load_error=1; nibble_count=3.
- "c" then LF -> with RAM_LOADER_LOWERCASE_EN: wdata 0xC000000000000000, no error; without: no write, load_error=1, nibble_count=0.
- Reset asserted during a stalled WRITE -> next cycle ceb=1, addr=0, state IDLE; a new "1" then LF writes 0x1000000000000000 to addr 0.
